uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Serial transmitter that sits directly downstream of the byte FIFO. It drains the FIFO and emits each word as an asynchronous UART frame on a single line.
- Frame format: start bit, WIDTH data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Pops the FIFO with a single-cycle get pulse and samples the FIFO's combinational data output in that same cycle.

Parameters:
- WIDTH, 8, data bits per frame; must match the FIFO WIDTH.
- DEPTH, 7, width of the FIFO size input; must match the FIFO DEPTH.
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- fifo_data_i  input  WIDTH  head-of-FIFO word; valid whenever fifo_size_i != 0.
- fifo_size_i  input  DEPTH  FIFO fill level; nonzero means data is available.
- fifo_get_o  output  1  single-cycle pop strobe to the FIFO.
- enable_i  input  1  permits new frames to start; sampled only at frame boundaries.
- tx_o  output  1  serial line; idle level is high.
- busy_o  output  1  high while a frame is on the line.

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-frame:
  - tx_o=1, fifo_get_o=0, busy_o=0.
  - state=IDLE; bit counter, divider counter and shift register cleared.
  - A partially sent frame is abandoned. Its word is already popped and is lost.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Launch condition: state is IDLE, enable_i=1 and fifo_size_i!=0.
  - In that cycle T: fifo_get_o=1, fifo_data_i is latched into the shift register, parity is computed.
  - T+1: state=START, tx_o=0, busy_o=1.
  - fifo_get_o is never high for more than one consecutive cycle per frame and is never asserted when fifo_size_i==0.
- Each bit is held on tx_o for exactly CLK_DIV cycles. The divider counts 0..CLK_DIV-1 and wraps; the state advances on the wrap.
- START -> DATA after CLK_DIV cycles.
- DATA:
  - tx_o = shift register bit 0; shift right once per bit.
  - After WIDTH bits, go to PARITY if the macro is defined, otherwise STOP.
- PARITY: one bit (see Optional Feature), then STOP.
- STOP: tx_o=1 for STOP_BITS*CLK_DIV cycles.
- Last cycle of STOP:
  - If enable_i=1 and fifo_size_i!=0, pop in that cycle as in the launch rule. The next cycle is START, so frames are gapless and busy_o stays high.
  - Otherwise the next state is IDLE and busy_o=0.
- Frame length: (1 + WIDTH + P + STOP_BITS) * CLK_DIV cycles, where P is 1 with parity and 0 without.
- enable_i dropping mid-frame has no effect on the current frame. It only blocks the next launch.
- FIFO data changing after the pop is ignored; the shift register holds the word.
- tx_o is registered, never combinational, so it is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - Parity bit = XOR of the data bits, inverted if PARITY_ODD=1.
  - Frame grows by CLK_DIV cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - PARITY_ODD is ignored.

Test Plan:
- Reset: assert rst_i mid-DATA -> tx_o=1, busy_o=0, fifo_get_o=0 in the same cycle; after release, no pop until fifo_size_i!=0.
- Single frame, CLK_DIV=4, no parity:
  - Stimulus: fifo_size_i=1, fifo_data_i=8'hA5, enable_i=1.
  - Response: one fifo_get_o pulse, then tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles (40 cycles), then IDLE.
- Back-to-back:
  - Stimulus: FIFO holds 8'h00 then 8'hFF.
  - Response: the second pop coincides with the last stop cycle of frame 1; the start bit of frame 2 follows with no idle cycle; busy_o is continuously high for 80 cycles.
- enable_i:
  - Stimulus: enable_i=0 with fifo_size_i=3.
  - Response: no pop, tx_o=1. Raise enable_i, then drop it 5 cycles into the frame -> exactly one frame sent, then IDLE.
- STOP_BITS=2, CLK_DIV=4: stop high time is 8 cycles; total frame 44 cycles.
- With UART_TX_PARITY_EN:
  - 8'h07 with PARITY_ODD=0 -> parity bit 1.
  - 8'h07 with PARITY_ODD=1 -> parity bit 0.
  - Frame length 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops words from an upstream FIFO and sends them as UART frames.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_fifo_drain #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 7,
  parameter int CLK_DIV    = 868,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic [DEPTH-1:0] fifo_size_i,
  output logic             fifo_get_o,
  input  logic             enable_i,
  output logic             tx_o,
  output logic             busy_o
);
  localparam int BW = $clog2(WIDTH + 1);
  if (CLK_DIV < 2 || CLK_DIV > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_tx_fifo_drain: illegal parameter value");
  end
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t           state_q, state_d;
  logic [15:0]      div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             tx_q, tx_d, busy_q, busy_d;
  logic             wrap, last_stop, launch;
  assign wrap       = div_q == 16'(CLK_DIV - 1);
  assign last_stop  = state_q == STOP && wrap && bit_q == BW'(STOP_BITS - 1);
  // Gated by rst_i so no pop can escape while the block is held in reset.
  assign launch     = !rst_i && enable_i && (|fifo_size_i) && (state_q == IDLE || last_stop);
  assign fifo_get_o = launch;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || wrap) ? '0 : div_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (launch) begin
      state_d = START;
      div_d   = '0;
      bit_d   = '0;
      sh_d    = fifo_data_i;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_data_i ^ PARITY_ODD[0];
`endif
    end else if (wrap) begin
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
        DATA: begin
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_d[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
`endif
        STOP: begin
          state_d = last_stop ? IDLE : STOP;
          busy_d  = !last_stop;
          bit_d   = last_stop ? bit_q : bit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: scoreboard bench; a line monitor decodes frames and checks them against queued words.
module tb_uart_tx_fifo_drain;
  localparam int W  = 8;
  localparam int D  = 7;
  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L  = 2 + W + P;
  localparam int L2 = 3 + W + P;
  typedef struct packed {logic [W-1:0] d; logic p;} exp_t;
  logic clk = 0, rst = 1, en = 0, en2 = 0;
  logic [W-1:0] fdata = '0, data2 = 8'h07;
  logic [D-1:0] fsize = '0, size2 = '0;
  logic get, tx, busy, get2, tx2, busy2, get_d = 0;
  logic [W-1:0] fq[$];
  exp_t sb[$];
  int checks = 0, errors = 0, pop_cnt = 0, viol = 0;
  always #5 clk = ~clk;
  uart_tx_fifo_drain #(.WIDTH(W), .DEPTH(D), .CLK_DIV(CD), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk_i(clk), .rst_i(rst), .fifo_data_i(fdata), .fifo_size_i(fsize), .fifo_get_o(get),
    .enable_i(en), .tx_o(tx), .busy_o(busy));
  uart_tx_fifo_drain #(.WIDTH(W), .DEPTH(D), .CLK_DIV(CD), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .fifo_data_i(data2), .fifo_size_i(size2), .fifo_get_o(get2),
    .enable_i(en2), .tx_o(tx2), .busy_o(busy2));
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic upd();
    fsize = D'(fq.size());
    fdata = fq.size() != 0 ? fq[0] : '0;
  endtask
  task automatic push(input logic [W-1:0] d, input logic p, input bit e);
    fq.push_back(d);
    if (e) sb.push_back({d, p});
    upd();
  endtask
  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_rise"}, int'(busy === 1'b1), 1);
  endtask
  task automatic count_busy(input string name, output int n);
    wait_busy(name);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || fsize != 0 || sb.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, "_idle"}, int'(busy === 1'b0 && sb.size() == 0), 1);
  endtask
  always @(posedge clk) get_d <= get;
  initial begin : fifo_model
    bit prev = 0;
    forever begin
      @(posedge clk);
      if (get === 1'b1) begin
        pop_cnt++;
        if (fsize == 0 || prev) viol++;
        prev = 1;
        #1;
        if (fq.size() != 0) void'(fq.pop_front());
        upd();
      end else prev = 0;
    end
  end
  initial begin : monitor
    logic [15:0] got, want;
    bit stable, bsy, abort;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        got = '0; stable = 1; bsy = 1; abort = 0;
        chk("pop_before_start", int'(get_d), 1);
        for (int k = 0; k < L * CD; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            abort = 1;
            break;
          end
          if (k % CD == 0) got[k/CD] = tx;
          else if (tx !== got[k/CD]) stable = 0;
          if (busy !== 1'b1) bsy = 0;
        end
        if (!abort) begin
          if (sb.size() == 0) chk("unexpected_frame", int'(got), -1);
          else begin
            e = sb.pop_front();
`ifdef UART_TX_PARITY_EN
            want = 16'({1'b1, e.p, e.d, 1'b0});
`else
            want = 16'({1'b1, e.d, 1'b0});
`endif
            chk("frame_bits", int'(got), int'(want));
          end
          chk("bit_hold", int'(stable), 1);
          chk("busy_in_frame", int'(bsy), 1);
        end
      end
    end
  end
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin : stim
    int n, base, k, run;
    logic [15:0] got2, want2;
    en = 1;
    repeat (3) @(negedge clk);
    push(8'hA5, 1'b0, 1);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_get", int'(get), 0);
    rst = 0;
    count_busy("single", n);
    chk("single_len", n, L * CD);
    push(8'h00, 1'b0, 1);
    push(8'hFF, 1'b0, 1);
    count_busy("b2b", n);
    chk("b2b_len", n, 2 * L * CD);
    push(8'h07, 1'b1, 1);
    count_busy("par", n);
    chk("par_len", n, L * CD);
    en = 0;
    base = pop_cnt;
    push(8'h3C, 1'b0, 0);
    push(8'hC3, 1'b0, 0);
    push(8'h5A, 1'b0, 0);
    repeat (20) @(negedge clk);
    chk("dis_pop", pop_cnt - base, 0);
    chk("dis_tx", int'(tx), 1);
    sb.push_back({8'h3C, 1'b0});
    en = 1;
    wait_busy("en");
    repeat (5) @(negedge clk);
    en = 0;
    repeat (L * CD + 10) @(negedge clk);
    chk("en_one_pop", pop_cnt - base, 1);
    chk("en_idle", int'(busy), 0);
    chk("en_left", fq.size(), 2);
    sb.push_back({8'hC3, 1'b0});
    sb.push_back({8'h5A, 1'b0});
    en = 1;
    wait_idle("en_drain");
    push(8'h96, 1'b0, 0);
    wait_busy("rst_mid");
    repeat (16) @(negedge clk);
    chk("mid_tx_low", int'(tx), 0);
    #2 rst = 1;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_get", int'(get), 0);
    base = pop_cnt;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("rst_nopop", pop_cnt - base, 0);
    chk("rst_line_idle", int'(tx), 1);
    push(8'h3C, 1'b0, 1);
    wait_idle("after_rst");
    en2 = 1;
    size2 = 1;
    @(posedge clk);
    chk("d2_get", int'(get2), 1);
    #1;
    size2 = 0;
    en2 = 0;
    @(negedge clk);
    k = 0; run = 0; got2 = '0;
    while (busy2 === 1'b1 && k < 100) begin
      if (k % CD == 0) got2[k/CD] = tx2;
      run = tx2 === 1'b1 ? run + 1 : 0;
      k++;
      @(negedge clk);
    end
`ifdef UART_TX_PARITY_EN
    want2 = 16'({2'b11, 1'b0, 8'h07, 1'b0});
`else
    want2 = 16'({2'b11, 8'h07, 1'b0});
`endif
    chk("d2_len", k, L2 * CD);
    chk("d2_bits", int'(got2), int'(want2));
    chk("d2_stop_high", run, 2 * CD);
    chk("d2_idle_tx", int'(tx2), 1);
    chk("get_protocol", viol, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
